// File: rtl/sme_result_collector_pkg.sv
// sme_pkg: shared widths, FSM state and result record for the SME result collector
package sme_pkg;
  localparam int PAT_W = 4;
  localparam int ADDR_W = 12;
  localparam int RES_W = 16;
  localparam int CNT_W = 13;
  localparam logic [CNT_W-1:0] CNT_MAX = 13'd4095;
  typedef enum logic [1:0] {COLLECT, DRAIN, DONE} state_t;
  typedef struct packed {
    logic [PAT_W-1:0] pattern_no;
    logic [ADDR_W-1:0] match_addr;
  } result_t;
endpackage

// File: rtl/sme_result_collector_if.sv
// sme_result_collector_if: SME result stream, readout port and status bundle
interface sme_result_collector_if;
  import sme_pkg::*;
  logic valid;
  logic [PAT_W-1:0] pattern_no;
  logic [ADDR_W-1:0] match_addr;
  logic finish;
  logic rd_en;
  logic [RES_W-1:0] rd_data;
  logic rd_valid;
  logic empty;
  logic full;
  logic overflow;
  logic proto_err;
  logic [PAT_W-1:0] cnt_sel;
  logic [CNT_W-1:0] cnt_out;
  logic [15:0] dup_cnt;
  logic done;
  modport master(
    output valid, pattern_no, match_addr, finish, rd_en, cnt_sel,
    input rd_data, rd_valid, empty, full, overflow, proto_err, cnt_out, dup_cnt, done
  );
  modport slave(
    input valid, pattern_no, match_addr, finish, rd_en, cnt_sel,
    output rd_data, rd_valid, empty, full, overflow, proto_err, cnt_out, dup_cnt, done
  );
endinterface

// File: rtl/sme_result_collector_fifo.sv
// sme_result_fifo: synchronous FIFO, registered read port, writes dropped when full
module sme_result_fifo #(
  parameter int DEPTH = 512,
  parameter int W = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic wr_en,
  input  logic [W-1:0] wr_data,
  input  logic rd_en,
  output logic [W-1:0] rd_data,
  output logic rd_valid,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wptr, rptr;
  logic push, pop;
  assign empty = wptr == rptr;
  assign full = wptr[AW] != rptr[AW] && wptr[AW-1:0] == rptr[AW-1:0];
  assign push = wr_en && !full;
  assign pop = rd_en && !empty;
  always_ff @(posedge clk)
    if (push) mem[wptr[AW-1:0]] <= wr_data;
  always_ff @(posedge clk) begin
    if (!reset) begin
      wptr <= '0;
      rptr <= '0;
      rd_data <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= pop;
      if (push) wptr <= wptr + 1'b1;
      if (pop) begin
        rd_data <= mem[rptr[AW-1:0]];
        rptr <= rptr + 1'b1;
      end
    end
  end
endmodule

// File: rtl/sme_result_collector.sv
// sme_result_collector: dedups SME results per pattern, counts them and buffers unique ones
module sme_result_collector import sme_pkg::*; #(
  parameter int DEPTH = 512,
  parameter int PNUM = 16
) (
  input logic clk,
  input logic reset,
  sme_result_collector_if.slave bus
);
  state_t state;
  logic [PNUM-1:0] seen;
  logic [ADDR_W-1:0] last_addr [PNUM];
  logic [CNT_W-1:0] count [PNUM];
  logic collect, uniq, push;
  result_t res;
  assign res = {bus.pattern_no, bus.match_addr};
  assign collect = state == COLLECT;
  // repeat = same address as the last accepted result of this pattern only
  assign uniq = !seen[bus.pattern_no] || last_addr[bus.pattern_no] != bus.match_addr;
  assign push = collect && bus.valid && uniq;
  assign bus.cnt_out = count[bus.cnt_sel];
  sme_result_fifo #(.DEPTH(DEPTH), .W(RES_W)) u_fifo (
    .clk(clk),
    .reset(reset),
    .wr_en(push),
    .wr_data(res),
    .rd_en(bus.rd_en),
    .rd_data(bus.rd_data),
    .rd_valid(bus.rd_valid),
    .full(bus.full),
    .empty(bus.empty)
  );
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= COLLECT;
      bus.done <= 1'b0;
      bus.overflow <= 1'b0;
      bus.proto_err <= 1'b0;
      bus.dup_cnt <= '0;
      seen <= '0;
      for (int i = 0; i < PNUM; i++) begin
        last_addr[i] <= '0;
        count[i] <= '0;
      end
    end else begin
      if (push) begin
        seen[bus.pattern_no] <= 1'b1;
        last_addr[bus.pattern_no] <= bus.match_addr;
        if (count[bus.pattern_no] != CNT_MAX) count[bus.pattern_no] <= count[bus.pattern_no] + 1'b1;
        if (bus.full) bus.overflow <= 1'b1;
      end
      if (collect && bus.valid && !uniq && bus.dup_cnt != '1) bus.dup_cnt <= bus.dup_cnt + 1'b1;
      if (!collect && bus.valid) bus.proto_err <= 1'b1;
      state <= collect && bus.finish ? DRAIN : state == DRAIN && bus.empty ? DONE : state;
      bus.done <= bus.done || (state == DRAIN && bus.empty);
    end
  end
endmodule
